// File: rtl/npu_pkg.sv
// Shared NPU width constants and the input-queue entry layout.
package npu_pkg;

  localparam int unsigned NPU_DATA_W     = 32;
  localparam int unsigned NPU_SHIFT_W    = 5;
  localparam int unsigned NPU_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [NPU_DATA_W-1:0]  data;
    logic [NPU_SHIFT_W-1:0] shift;
  } npu_entry_t;

endpackage

// File: rtl/npu_fifo_ctrl.sv
// Pointer/occupancy/error bookkeeping for a flop-based NPU queue.
module npu_fifo_ctrl #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flush,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          valid,
  output logic          full,
  output logic          err
);

  logic pop_ok;
  logic push_ok;
  logic overflow;
  logic underflow;

  assign valid     = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_ok    = rd_en & valid;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign push_ok   = wr_en & (~full | pop_ok);
  assign overflow  = wr_en & ~push_ok;
  assign underflow = rd_en & ~valid;

  assign push = push_ok & ~flush;
  assign pop  = pop_ok & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      err <= err | overflow | underflow;
    end
  end

endmodule

// File: rtl/npu_input_fifo.sv
// First-word-fall-through operand queue feeding npu_int2fixed; each entry
// carries the shift-down amount that was current when it was written.
module npu_input_fifo
  import npu_pkg::*;
#(
  parameter int unsigned DEPTH   = NPU_FIFO_DEPTH,
  parameter int unsigned DATA_W  = NPU_DATA_W,
  parameter int unsigned SHIFT_W = NPU_SHIFT_W,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               npu_if_wr_en,
  input  logic [DATA_W-1:0]  npu_if_wr_data,
  input  logic               npu_if_cfg_we,
  input  logic [SHIFT_W-1:0] npu_if_cfg_shift,
  input  logic               npu_if_rd_en,
  input  logic               npu_if_flush,
  output logic [DATA_W-1:0]  npu_i2f_datain,
  output logic [SHIFT_W-1:0] npu_i2f_shiftdownby,
  output logic               npu_if_valid,
  output logic               npu_if_full,
  output logic [AW:0]        npu_if_count,
  output logic               npu_if_err
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHIFT_W-1:0] shift;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [SHIFT_W-1:0] shift_reg;
  logic               push;
  logic               pop;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  npu_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (npu_if_wr_en),
    .rd_en  (npu_if_rd_en),
    .flush  (npu_if_flush),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (npu_if_count),
    .valid  (npu_if_valid),
    .full   (npu_if_full),
    .err    (npu_if_err)
  );

  // Loads even during flush; a push in the same cycle sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             shift_reg <= '0;
    else if (npu_if_cfg_we) shift_reg <= npu_if_cfg_shift;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: npu_if_wr_data, shift: shift_reg};
  end

  assign head                = npu_if_valid ? mem[rd_ptr] : '0;
  assign npu_i2f_datain      = head.data;
  assign npu_i2f_shiftdownby = head.shift;

  // pop is only consumed through the shared pointer logic
  logic unused_pop;
  assign unused_pop = pop;

endmodule

// File: tb/tb_npu_input_fifo.sv
// Self-checking bench for npu_input_fifo: hand table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_npu_input_fifo;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] datain;
  logic [4:0]  shiftdownby;
  logic        valid;
  logic        full;
  logic [3:0]  count;
  logic        err;

  int checks = 0;
  int failures = 0;

  npu_input_fifo #(.DEPTH(DEPTH), .DATA_W(32), .SHIFT_W(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .npu_if_wr_en        (wr_en),
    .npu_if_wr_data      (wr_data),
    .npu_if_cfg_we       (cfg_we),
    .npu_if_cfg_shift    (cfg_shift),
    .npu_if_rd_en        (rd_en),
    .npu_if_flush        (flush),
    .npu_i2f_datain      (datain),
    .npu_i2f_shiftdownby (shiftdownby),
    .npu_if_valid        (valid),
    .npu_if_full         (full),
    .npu_if_count        (count),
    .npu_if_err          (err)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {data, tag} plus shift and sticky err.
  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
  } ent_t;
  ent_t       q[$];
  logic [4:0] m_shift = '0;
  logic       m_err = 1'b0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        cfg;
    logic [4:0]  sh;
    logic        rd;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_tag;
    logic [3:0]  e_count;
    logic        e_full;
    logic        e_err;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_step(input logic w, input logic [31:0] d, input logic c,
                                     input logic [4:0] s, input logic r, input logic f);
    bit do_pop;
    bit do_push;
    if (f) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      do_pop  = r && (q.size() > 0);
      do_push = w && (q.size() < DEPTH || do_pop);
      if (w && !do_push) m_err = 1'b1;
      if (r && q.size() == 0) m_err = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{d: d, s: m_shift});
    end
    if (c) m_shift = s;
  endfunction

  task automatic drive(input logic w, input logic [31:0] d, input logic c,
                       input logic [4:0] s, input logic r, input logic f);
    wr_en = w; wr_data = d; cfg_we = c; cfg_shift = s; rd_en = r; flush = f;
  endtask

  task automatic cycle(input logic w, input logic [31:0] d, input logic c,
                       input logic [4:0] s, input logic r, input logic f);
    drive(w, d, c, s, r, f);
    @(posedge clk);
    #1;
    model_step(w, d, c, s, r, f);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(q.size() > 0));
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    check({tag, ".err"},   32'(err),   32'(m_err));
    check({tag, ".data"},  datain,      q.size() > 0 ? q[0].d : 32'h0);
    check({tag, ".tag"},   32'(shiftdownby), q.size() > 0 ? 32'(q[0].s) : 32'h0);
  endtask

  logic [31:0] vals[DEPTH];

  initial begin
    // wr data cfg sh rd fl | valid data tag count full err
    vecs[0]  = '{0, 32'h0,      1, 5'd3, 0, 0,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[1]  = '{1, 32'hC53A,   0, 5'd0, 0, 0,  1, 32'hC53A,   5'd3, 4'd1, 0, 0};
    vecs[2]  = '{0, 32'h0,      0, 5'd0, 1, 0,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[3]  = '{0, 32'h0,      1, 5'd0, 0, 0,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[4]  = '{1, 32'h111,    0, 5'd0, 0, 0,  1, 32'h111,    5'd0, 4'd1, 0, 0};
    vecs[5]  = '{1, 32'h222,    1, 5'd5, 0, 0,  1, 32'h111,    5'd0, 4'd2, 0, 0};
    vecs[6]  = '{1, 32'h333,    0, 5'd0, 0, 0,  1, 32'h111,    5'd0, 4'd3, 0, 0};
    vecs[7]  = '{0, 32'h0,      0, 5'd0, 1, 0,  1, 32'h222,    5'd0, 4'd2, 0, 0};
    vecs[8]  = '{0, 32'h0,      0, 5'd0, 1, 0,  1, 32'h333,    5'd5, 4'd1, 0, 0};
    vecs[9]  = '{0, 32'h0,      0, 5'd0, 1, 0,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[10] = '{0, 32'h0,      0, 5'd0, 1, 0,  0, 32'h0,      5'd0, 4'd0, 0, 1};
    vecs[11] = '{0, 32'h0,      0, 5'd0, 0, 1,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[12] = '{1, 32'hDEAD,   0, 5'd0, 1, 0,  1, 32'hDEAD,   5'd5, 4'd1, 0, 1};
    vecs[13] = '{1, 32'h5,      1, 5'd7, 0, 1,  0, 32'h0,      5'd0, 4'd0, 0, 0};
    vecs[14] = '{1, 32'h9,      0, 5'd0, 0, 0,  1, 32'h9,      5'd7, 4'd1, 0, 0};
    vecs[15] = '{0, 32'h0,      0, 5'd0, 1, 0,  0, 32'h0,      5'd0, 4'd0, 0, 0};

    #12;
    check("reset.valid", 32'(valid), 32'h0);
    check("reset.data",  datain, 32'h0);
    check("reset.count", 32'(count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_reset");

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].wr, vecs[i].data, vecs[i].cfg, vecs[i].sh, vecs[i].rd, vecs[i].fl);
      check($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.data", i),  datain, vecs[i].e_data);
      check($sformatf("vec%0d.tag", i),   32'(shiftdownby), 32'(vecs[i].e_tag));
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d.full", i),  32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d.err", i),   32'(err), 32'(vecs[i].e_err));
      if (i == 1) check("conv_out", datain >> shiftdownby, 32'h18A7);
    end

    // Fill, overflow, drain, underflow.
    cycle(0, '0, 0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = $urandom;
      cycle(1, vals[i], 0, '0, 0, 0);
    end
    check("fill.count", 32'(count), 32'd8);
    check("fill.full",  32'(full), 32'h1);
    check("fill.err",   32'(err), 32'h0);
    cycle(1, 32'hBAD0BAD0, 0, '0, 0, 0);
    check("ovf.err",   32'(err), 32'h1);
    check("ovf.count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.data", i), datain, vals[i]);
      cycle(0, '0, 0, '0, 1, 0);
    end
    check("drain.valid", 32'(valid), 32'h0);
    cycle(0, '0, 0, '0, 1, 0);
    check("unf.err", 32'(err), 32'h1);
    check_model("unf");

    // Full with simultaneous push and pop.
    cycle(0, '0, 0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h100 + 32'(i), 0, '0, 0, 0);
    cycle(1, 32'h1FF, 0, '0, 1, 0);
    check("fullpp.count", 32'(count), 32'd8);
    check("fullpp.err",   32'(err), 32'h0);
    check("fullpp.head",  datain, 32'h101);
    check_model("fullpp");

    // Flush with pending push keeps the shift register.
    cycle(0, '0, 1, 5'd11, 0, 0);
    cycle(0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'h40 + 32'(i), 0, '0, 0, 0);
    cycle(1, 32'h77, 0, '0, 0, 1);
    check("flush.count", 32'(count), 32'h0);
    check("flush.valid", 32'(valid), 32'h0);
    check("flush.err",   32'(err), 32'h0);
    cycle(1, 32'h88, 0, '0, 0, 0);
    check("flush.tag", 32'(shiftdownby), 32'd11);
    check_model("flush");

    // Randomized traffic with phases biased towards full and empty.
    for (int i = 0; i < 800; i++) begin
      int unsigned wp;
      int unsigned rp;
      wp = (i / 100) % 2 == 0 ? 75 : 35;
      rp = (i / 100) % 2 == 0 ? 35 : 75;
      cycle($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 7) == 0,
            5'($urandom), $urandom_range(0, 99) < rp, $urandom_range(0, 63) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-burst.
    cycle(0, '0, 1, 5'd9, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 32'hA0 + 32'(i), 0, '0, 0, 0);
    check("prerst.count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.data",  datain, 32'h0);
    check("rst.tag",   32'(shiftdownby), 32'h0);
    check("rst.count", 32'(count), 32'h0);
    check("rst.err",   32'(err), 32'h0);
    q.delete();
    m_shift = '0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'hCAFE, 0, '0, 0, 0);
    check("rst.newtag", 32'(shiftdownby), 32'h0);
    check_model("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/npu_input_fifo.md
# npu_input_fifo

Buffers 32-bit integer operands written by the host-side NPU interface and presents them, one per handshake, to the integer-to-fixed-point converter (npu_int2fixed). Each entry is tagged with the shift-down amount in force when it was written, so shift changes never corrupt operands already queued. First-word-fall-through queue: the head entry drives the converter inputs directly, and the downstream neuron loader pops it once the converted value is consumed.

## Interface

- DEPTH, 8, number of entries; power of two, minimum 2
- DATA_W, 32, integer operand width
- SHIFT_W, 5, shift-amount width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- npu_if_wr_en  in  1  push npu_if_wr_data this cycle
- npu_if_wr_data  in  DATA_W  integer operand
- npu_if_cfg_we  in  1  load npu_if_cfg_shift into the shift register
- npu_if_cfg_shift  in  SHIFT_W  new shift-down amount
- npu_if_rd_en  in  1  pop head entry
- npu_if_flush  in  1  synchronous discard of all entries
- npu_i2f_datain  out  DATA_W  head operand to converter
- npu_i2f_shiftdownby  out  SHIFT_W  head entry's shift tag
- npu_if_valid  out  1  head entry present (not empty)
- npu_if_full  out  1  DEPTH entries held
- npu_if_count  out  log2(DEPTH)+1  occupancy
- npu_if_err  out  1  sticky overflow/underflow flag

## Operation

- Storage: DEPTH entries of {DATA_W data, SHIFT_W tag}; wr_ptr/rd_ptr of log2(DEPTH) bits wrap modulo DEPTH; count tracked separately.
- Shift register: loaded on npu_if_cfg_we. A push tags the entry with the register value *before* that edge. Cfg write and push in the same cycle therefore tag the old value.
- Push accepted when npu_if_wr_en and (not full, or npu_if_rd_en with valid in the same cycle).
- Pop accepted when npu_if_rd_en and valid.
- Push while full with no pop: data dropped, err set. Pop while empty: ignored, err set. Simultaneous push+pop while empty: push accepted, pop counts as underflow (err set).
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Flush: highest priority; pointers and count go to 0, err cleared, shift register unchanged; any push/pop that cycle ignored. A cfg write in the flush cycle still takes effect.
- Outputs when empty: npu_i2f_datain = 0, npu_i2f_shiftdownby = 0; otherwise the entry at rd_ptr.
- err cleared only by reset or flush.

## Timing

- Reset (async assert, sync release): count 0, pointers 0, shift register 0, err 0, valid 0, full 0, datain 0, shiftdownby 0.
- Push at edge N: entry visible and valid high from after edge N (latency 1 cycle). Storage is flop-based, so head outputs are combinational from the array with no read latency.
- Pop at edge N: next entry (or zeros) visible after edge N.
- full/valid/count derive from registered count; no combinational path from wr_en/rd_en to the flags.
- Reset asserted mid-burst: all contents lost immediately; no partial entry survives.

## Structure

- Shared package npu_pkg: NPU_DATA_W=32, NPU_SHIFT_W=5, NPU_FIFO_DEPTH=8, an entry typedef {data, shift}. npu_int2fixed uses the same width constants.
- One natural sub-module: npu_fifo_ctrl (pointers, count, accept logic, err), reusable by the output-side queue. The storage array and shift register stay in the top module.

## Test plan

- Reset, cfg shift=3, push 0x0000C53A, pop -> valid 1 cycle after push, datain 0x0000C53A, shiftdownby 3; downstream converter output 0x18A7; after pop valid 0, outputs 0.
- Push A (shift 0), cfg 5 in same cycle as push B, push C -> tags 0, 0, 5 popped in order A, B, C.
- Push 8 entries -> full=1, count=8; 9th push dropped, err=1; pop 8 returns values in order, no corruption; pop when empty keeps err=1.
- With full, push+pop same cycle -> count stays 8, err stays 0. Wrap pointers twice with interleaved traffic; order is preserved.
- Push 4, flush with simultaneous push -> count 0, valid 0, err 0, shift register retained.
- Push 3, assert rst_n low mid-cycle -> outputs zero immediately, count 0, shift 0.
